// File: rtl/uart_reg_if.sv
// Byte-wide register bus shared with the GPIO block: address, write data,
// combinational read data, and one-clk write/read strobes.
interface uart_reg_if;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_in;
  logic [7:0] reg_data_out;
  logic       reg_write;
  logic       reg_read;

  modport master (output reg_addr, output reg_data_in, output reg_write,
                  output reg_read, input reg_data_out);
  modport slave  (input reg_addr, input reg_data_in, input reg_write,
                  input reg_read, output reg_data_out);
endinterface

// File: rtl/uart_unit.sv
// 8N1 UART for the GPIO pin mux: 16x-oversampled receiver feeding a small RX
// FIFO, and a transmitter with a one-byte holding register.
module uart_unit #(
  parameter int DIV_W    = 16,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       interrupt,
  uart_reg_if.slave  bus
);
  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_ARM, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic [DIV_W-1:0] div_r, tick_cnt_r;
  logic             tick_s;
  logic             rx_meta_r, rx_sync_r;
  logic [1:0]       ien_r;
  logic             ferr_r, ovr_r, tx_busy_r, tx_empty_r;

  rx_state_t        rx_state_r, rx_state_nxt_s;
  logic [3:0]       rx_tick_r;
  logic [2:0]       rx_bit_r;
  logic [7:0]       rx_shift_r;
  logic             rx_mid_s, rx_sample_s, rx_push_s, rx_ovr_set_s, rx_ferr_set_s;

  logic [7:0]       fifo_mem_r [RX_DEPTH];
  logic [PTR_W-1:0] rx_wptr_r, rx_rptr_r;
  logic [CNT_W-1:0] rx_count_r;
  logic             fifo_full_s, rx_avail_s, rx_pop_s;

  tx_state_t        tx_state_r, tx_state_nxt_s;
  logic [3:0]       tx_tick_r;
  logic [2:0]       tx_bit_r;
  logic [7:0]       tx_shift_r, tx_hold_r;
  logic             uart_tx_r;
  logic             tx_end_s, tx_load_s, tx_start_bit_s, tx_shift_s, tx_stop_bit_s, tx_done_s;

  logic             wr_data_s, wr_stat_s, wr_ien_s, wr_div_lo_s, wr_div_hi_s;

  assign wr_data_s   = bus.reg_write && (bus.reg_addr == 3'd0);
  assign wr_stat_s   = bus.reg_write && (bus.reg_addr == 3'd1);
  assign wr_ien_s    = bus.reg_write && (bus.reg_addr == 3'd2);
  assign wr_div_lo_s = bus.reg_write && (bus.reg_addr == 3'd3);
  assign wr_div_hi_s = bus.reg_write && (bus.reg_addr == 3'd4);

  // Baud tick: one pulse every div+1 clocks, restarted by any divisor write.
  assign tick_s = (tick_cnt_r == div_r);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_r <= '0;
      div_r      <= '0;
    end else begin
      if (wr_div_lo_s || wr_div_hi_s) tick_cnt_r <= '0;
      else if (tick_s)                tick_cnt_r <= '0;
      else                            tick_cnt_r <= tick_cnt_r + DIV_W'(1);
      if (wr_div_lo_s) div_r[7:0]  <= bus.reg_data_in;
      if (wr_div_hi_s) div_r[15:8] <= bus.reg_data_in;
    end
  end

  // Two-flop synchroniser on the incoming serial line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) {rx_sync_r, rx_meta_r} <= 2'b11;
    else       {rx_sync_r, rx_meta_r} <= {rx_meta_r, uart_rx};
  end

  // RX state register and bit datapath; rx_tick_r counts ticks within each bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_r <= RX_IDLE;
      rx_tick_r  <= 4'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      rx_state_r <= rx_state_nxt_s;
      if (tick_s) rx_tick_r <= (rx_state_r == RX_IDLE) ? 4'd0 : rx_tick_r + 4'd1;
      if (rx_state_r == RX_IDLE) rx_bit_r <= 3'd0;
      else if (rx_sample_s)      rx_bit_r <= rx_bit_r + 3'd1;
      if (rx_sample_s) rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
    end
  end

  assign rx_mid_s = tick_s && (rx_tick_r == 4'd8);

  // RX next state.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE:  if (tick_s && !rx_sync_r) rx_state_nxt_s = RX_START; else rx_state_nxt_s = RX_IDLE;
      RX_START: if (rx_mid_s) rx_state_nxt_s = rx_sync_r ? RX_IDLE : RX_DATA; else rx_state_nxt_s = RX_START;
      RX_DATA:  if (rx_mid_s && (rx_bit_r == 3'd7)) rx_state_nxt_s = RX_STOP; else rx_state_nxt_s = RX_DATA;
      RX_STOP:  if (rx_mid_s) rx_state_nxt_s = RX_IDLE; else rx_state_nxt_s = RX_STOP;
      default:  rx_state_nxt_s = RX_IDLE;
    endcase
  end

  // RX outputs: data sampling and stop-bit verdict.
  always_comb begin
    rx_sample_s   = 1'b0;
    rx_push_s     = 1'b0;
    rx_ovr_set_s  = 1'b0;
    rx_ferr_set_s = 1'b0;
    case (rx_state_r)
      RX_DATA: rx_sample_s = rx_mid_s;
      RX_STOP: begin
        rx_push_s     = rx_mid_s && rx_sync_r && !fifo_full_s;
        rx_ovr_set_s  = rx_mid_s && rx_sync_r && fifo_full_s;
        rx_ferr_set_s = rx_mid_s && !rx_sync_r;
      end
      default: rx_sample_s = 1'b0;
    endcase
  end

  assign fifo_full_s = (rx_count_r == CNT_W'(RX_DEPTH));
  assign rx_avail_s  = (rx_count_r != CNT_W'(0));
  assign rx_pop_s    = bus.reg_read && (bus.reg_addr == 3'd0) && rx_avail_s;

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (rx_push_s) fifo_mem_r[rx_wptr_r] <= rx_shift_r;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr_r  <= '0;
      rx_rptr_r  <= '0;
      rx_count_r <= '0;
    end else begin
      if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_W'(1);
      if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_W'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + CNT_W'(1);
        2'b01:   rx_count_r <= rx_count_r - CNT_W'(1);
        default: rx_count_r <= rx_count_r;
      endcase
    end
  end

  // Sticky error flags (a set in the same clk beats the clear) and interrupt enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ferr_r <= 1'b0;
      ovr_r  <= 1'b0;
      ien_r  <= 2'b00;
    end else begin
      if (rx_ferr_set_s)                        ferr_r <= 1'b1;
      else if (wr_stat_s && bus.reg_data_in[4]) ferr_r <= 1'b0;
      if (rx_ovr_set_s)                         ovr_r  <= 1'b1;
      else if (wr_stat_s && bus.reg_data_in[3]) ovr_r  <= 1'b0;
      if (wr_ien_s) ien_r <= bus.reg_data_in[1:0];
    end
  end

  // TX state register, shifter, holding register and serial output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      tx_tick_r  <= 4'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_hold_r  <= 8'h00;
      tx_empty_r <= 1'b1;
      tx_busy_r  <= 1'b0;
      uart_tx_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nxt_s;
      if (tick_s) tx_tick_r <= (tx_state_r == TX_IDLE || tx_state_r == TX_ARM) ? 4'd0 : tx_tick_r + 4'd1;
      if (tx_start_bit_s) tx_bit_r <= 3'd0;
      else if (tx_shift_s && tx_state_r == TX_DATA) tx_bit_r <= tx_bit_r + 3'd1;
      if (tx_load_s)       tx_shift_r <= tx_hold_r;
      else if (tx_shift_s) tx_shift_r <= {1'b0, tx_shift_r[7:1]};
      if (wr_data_s && tx_empty_r) tx_hold_r <= bus.reg_data_in;
      if (tx_load_s)                    tx_empty_r <= 1'b1;
      else if (wr_data_s && tx_empty_r) tx_empty_r <= 1'b0;
      if (tx_load_s)      tx_busy_r <= 1'b1;
      else if (tx_done_s) tx_busy_r <= 1'b0;
      if (tx_start_bit_s)     uart_tx_r <= 1'b0;
      else if (tx_shift_s)    uart_tx_r <= tx_shift_r[0];
      else if (tx_stop_bit_s) uart_tx_r <= 1'b1;
    end
  end

  assign tx_end_s = tick_s && (tx_tick_r == 4'd15);

  // TX next state; STOP chains straight into START when a byte is waiting.
  always_comb begin
    tx_state_nxt_s = tx_state_r;
    case (tx_state_r)
      TX_IDLE:  tx_state_nxt_s = tx_empty_r ? TX_IDLE : TX_ARM;
      TX_ARM:   tx_state_nxt_s = tick_s ? TX_START : TX_ARM;
      TX_START: tx_state_nxt_s = tx_end_s ? TX_DATA : TX_START;
      TX_DATA:  tx_state_nxt_s = (tx_end_s && tx_bit_r == 3'd7) ? TX_STOP : TX_DATA;
      TX_STOP:  if (tx_end_s) tx_state_nxt_s = tx_empty_r ? TX_IDLE : TX_START; else tx_state_nxt_s = TX_STOP;
      default:  tx_state_nxt_s = TX_IDLE;
    endcase
  end

  // TX outputs: datapath strobes per state.
  always_comb begin
    tx_load_s      = 1'b0;
    tx_start_bit_s = 1'b0;
    tx_shift_s     = 1'b0;
    tx_stop_bit_s  = 1'b0;
    tx_done_s      = 1'b0;
    case (tx_state_r)
      TX_IDLE:  tx_load_s = !tx_empty_r;
      TX_ARM:   tx_start_bit_s = tick_s;
      TX_START: tx_shift_s = tx_end_s;
      TX_DATA: begin
        tx_shift_s    = tx_end_s && (tx_bit_r != 3'd7);
        tx_stop_bit_s = tx_end_s && (tx_bit_r == 3'd7);
      end
      TX_STOP: begin
        tx_load_s      = tx_end_s && !tx_empty_r;
        tx_start_bit_s = tx_end_s && !tx_empty_r;
        tx_done_s      = tx_end_s && tx_empty_r;
      end
      default: tx_load_s = 1'b0;
    endcase
  end

  assign uart_tx   = uart_tx_r;
  assign interrupt = (ien_r[0] && (rx_avail_s || ovr_r || ferr_r)) || (ien_r[1] && tx_empty_r);

  // Read mux.
  always_comb begin
    case (bus.reg_addr)
      3'd0:    bus.reg_data_out = rx_avail_s ? fifo_mem_r[rx_rptr_r] : 8'h00;
      3'd1:    bus.reg_data_out = {3'b000, ferr_r, ovr_r, tx_busy_r, tx_empty_r, rx_avail_s};
      3'd2:    bus.reg_data_out = {6'b000000, ien_r};
      3'd3:    bus.reg_data_out = div_r[7:0];
      3'd4:    bus.reg_data_out = div_r[15:8];
      default: bus.reg_data_out = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_uart_unit.sv
// Directed bench for uart_unit: register table, TX waveform, loopback,
// overflow, framing error, glitch rejection, interrupt and reset mid-frame.
module tb_uart_unit;
  logic clk, reset, rx_line, loop_en, rx_pin, uart_tx, irq;
  int   total, bad;

  uart_reg_if bus ();

  assign rx_pin = loop_en ? uart_tx : rx_line;

  uart_unit dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (rx_pin),
    .uart_tx   (uart_tx),
    .interrupt (irq),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_data_in = d; bus.reg_write = 1'b1;
    @(negedge clk);
    bus.reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_read = 1'b1;
    #1 d = bus.reg_data_out;
    @(negedge clk);
    bus.reg_read = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] d);
    bus.reg_addr = a;
    #1 d = bus.reg_data_out;
  endtask

  // One frame at div=3 (64 clk per bit), followed by one idle bit time.
  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    rx_line = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (64) @(negedge clk);
    end
    rx_line = stop_v;
    repeat (64) @(negedge clk);
    rx_line = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    logic [7:0] d, txb;
    logic       found;
    int         n;

    total = 0; bad = 0;
    reset = 1'b1; rx_line = 1'b1; loop_en = 1'b0;
    bus.reg_addr = 3'd0; bus.reg_data_in = 8'h00; bus.reg_write = 1'b0; bus.reg_read = 1'b0;

    vecs[0] = '{3'd2, 8'h02, 8'h02, 1'b1};
    vecs[1] = '{3'd2, 8'h01, 8'h01, 1'b0};
    vecs[2] = '{3'd2, 8'hFC, 8'h00, 1'b0};
    vecs[3] = '{3'd3, 8'h12, 8'h12, 1'b0};
    vecs[4] = '{3'd4, 8'h34, 8'h34, 1'b0};
    vecs[5] = '{3'd5, 8'hFF, 8'h00, 1'b0};
    vecs[6] = '{3'd7, 8'hAA, 8'h00, 1'b0};
    vecs[7] = '{3'd1, 8'h18, 8'h02, 1'b0};
    vecs[8] = '{3'd3, 8'h00, 8'h00, 1'b0};
    vecs[9] = '{3'd4, 8'h00, 8'h00, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_uart_tx", {7'd0, uart_tx}, 8'h01);
    check("rst_irq", {7'd0, irq}, 8'h00);
    peek(3'd1, d); check("rst_status", d, 8'h02);
    peek(3'd0, d); check("rst_data_peek", d, 8'h00);
    reg_rd(3'd0, d); check("rst_data_read_empty", d, 8'h00);
    peek(3'd1, d); check("rst_status_after_read", d, 8'h02);

    // Register table.
    for (int i = 0; i < 10; i++) begin
      reg_wr(vecs[i].addr, vecs[i].wdata);
      peek(vecs[i].addr, d);
      check($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {7'd0, irq}, {7'd0, vecs[i].exp_irq});
    end

    // TX waveform at div=0: one bit is 16 clk.
    txb = 8'hA5;
    reg_wr(3'd0, txb);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (uart_tx == 1'b0) found = 1'b1; else @(negedge clk);
    end
    check("tx_start_seen", {7'd0, found}, 8'h01);
    if (found) begin
      for (int k = 0; k < 170; k++) begin
        logic e;
        if (k != 0) @(negedge clk);
        if (k < 16)       e = 1'b0;
        else if (k < 144) e = txb[(k - 16) / 16];
        else              e = 1'b1;
        check($sformatf("tx_wave_k%0d", k), {7'd0, uart_tx}, {7'd0, e});
        if (k == 8)   begin peek(3'd1, d); check("tx_status_mid", d, 8'h06); end
        if (k == 159) begin peek(3'd1, d); check("tx_busy_last", d, 8'h06); end
        if (k == 160) begin peek(3'd1, d); check("tx_busy_clear", d, 8'h02); end
      end
    end

    // Loopback at div=3, two bytes back-to-back.
    reg_wr(3'd3, 8'h03);
    loop_en = 1'b1;
    reg_wr(3'd0, 8'h3C);
    reg_wr(3'd0, 8'hC3);
    n = 0; found = 1'b0;
    while (n < 3000 && !found) begin
      @(negedge clk); n++;
      peek(3'd1, d);
      if (d[2] == 1'b0) found = 1'b1;
    end
    check("b2b_done", {7'd0, found}, 8'h01);
    check("b2b_no_gap", {7'd0, (n >= 1275 && n <= 1290)}, 8'h01);
    repeat (10) @(negedge clk);
    loop_en = 1'b0;
    peek(3'd1, d); check("loop_status", d, 8'h03);
    reg_rd(3'd0, d); check("loop_byte0", d, 8'h3C);
    reg_rd(3'd0, d); check("loop_byte1", d, 8'hC3);
    peek(3'd1, d); check("loop_empty", d, 8'h02);

    // Overflow: five frames, no reads.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    peek(3'd1, d); check("ovr_status", d, 8'h0B);
    check("ovr_irq_disabled", {7'd0, irq}, 8'h00);
    reg_rd(3'd0, d); check("ovr_b0", d, 8'h11);
    reg_rd(3'd0, d); check("ovr_b1", d, 8'h22);
    reg_rd(3'd0, d); check("ovr_b2", d, 8'h33);
    reg_rd(3'd0, d); check("ovr_b3", d, 8'h44);
    peek(3'd1, d); check("ovr_drained", d, 8'h0A);
    reg_wr(3'd1, 8'h08);
    peek(3'd1, d); check("ovr_cleared", d, 8'h02);

    // Framing error.
    send_frame(8'h5A, 1'b0);
    peek(3'd1, d); check("ferr_status", d, 8'h12);
    reg_wr(3'd1, 8'h10);
    peek(3'd1, d); check("ferr_cleared", d, 8'h02);

    // 4-tick glitch on the idle line.
    rx_line = 1'b0;
    repeat (16) @(negedge clk);
    rx_line = 1'b1;
    repeat (200) @(negedge clk);
    peek(3'd1, d); check("glitch_status", d, 8'h02);

    // RX interrupt.
    reg_wr(3'd2, 8'h01);
    check("irq_before", {7'd0, irq}, 8'h00);
    send_frame(8'h55, 1'b1);
    check("irq_after_push", {7'd0, irq}, 8'h01);
    reg_rd(3'd0, d); check("irq_byte", d, 8'h55);
    check("irq_after_read", {7'd0, irq}, 8'h00);

    // Reset mid-TX with a byte waiting in the FIFO.
    send_frame(8'h99, 1'b1);
    reg_wr(3'd0, 8'hF0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (uart_tx == 1'b0) found = 1'b1; else @(negedge clk);
    end
    check("rst_tx_started", {7'd0, found}, 8'h01);
    repeat (20) @(negedge clk);
    check("rst_tx_low_before", {7'd0, uart_tx}, 8'h00);
    reset = 1'b1;
    #1 check("rst_mid_uart_tx", {7'd0, uart_tx}, 8'h01);
    check("rst_mid_irq", {7'd0, irq}, 8'h00);
    peek(3'd1, d); check("rst_mid_status", d, 8'h02);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    peek(3'd0, d); check("rst_mid_fifo", d, 8'h00);
    for (int k = 0; k < 4; k++) begin
      repeat (40) @(negedge clk);
      check($sformatf("rst_idle_k%0d", k), {7'd0, uart_tx}, 8'h01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global timeout guard.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
